iob_cache_axi_mem: RTL and testbench
====================================

Name: iob_cache_axi_mem

Overview:
AXI4 slave memory directly downstream of the cache's AXI4 back-end master; it consumes the cache's line-refill read bursts and write-through/write-back write bursts.
- Serves as the back-end target in cache simulation and FPGA test systems.
- Backed by a dual-port byte-enabled RAM.
- Read and write channels are independent state machines.

Parameters:
ADDR_W, 32, AXI address width (matches cache BE_ADDR_W)
DATA_W, 32, AXI data width (matches cache BE_DATA_W); power of 2, >= 8
MEM_ADDR_W, 16, byte-address bits actually decoded; depth = 2**MEM_ADDR_W/(DATA_W/8) words
ID_W, 1, AXI ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address
axi_awlock/awcache/awprot/awqos  in  1/4/3/4  ignored
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data
axi_wready  out  1  write data ready
axi_bid/bresp/bvalid  out  ID_W/2/1  write response
axi_bready  in  1  response ready
axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address
axi_arlock/arcache/arprot/arqos  in  1/4/3/4  ignored
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data
axi_rready  in  1  read data ready

Behaviour:
- Reset: all outputs registered. Every ready/valid is 0 and bresp/rresp/rdata/rid/bid are 0 while rst=1. FSMs return to IDLE, aborting any burst in progress; no response is issued for it. RAM contents are preserved.
- Addressing: word index = addr[MEM_ADDR_W-1:log2(DATA_W/8)]. Upper bits and low byte bits are ignored. Index increments by 1 per beat and wraps modulo depth.
- Burst type and size: awburst/arburst are treated as INCR; awsize/arsize are treated as full width.
- Write FSM:
  - W_IDLE: axi_awready=1. On awvalid&awready, latch id, index, len, clear beat counter, go W_DATA (awready=0 next cycle).
  - W_DATA: axi_wready=1. On each wvalid&wready, write bytes selected by wstrb at the current index, then index+1 and beat+1. Burst ends on the beat where beat==len. Go W_RESP.
  - Error flag: set if wlast=0 on the final beat or wlast=1 on an earlier beat; data is still written.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error flag else 2'b00. Hold until bready, then W_IDLE.
  - Minimum spacing: 1 cycle from AW handshake to first wready.
- Read FSM:
  - R_IDLE: axi_arready=1. On handshake, latch id, index, len, go R_FETCH.
  - R_FETCH: RAM read issued; 1-cycle RAM latency. Go R_DATA.
  - R_DATA: rvalid=1, rdata=RAM word, rid=latched id, rresp=2'b00, rlast=(beat==len). rdata, rlast and rid stay stable while rready=0.
  - On rready: if rlast go R_IDLE, else index+1, beat+1, go R_FETCH.
  - Timing: first rvalid 2 cycles after AR handshake; consecutive beats at most 1 every 2 cycles.
- Concurrency: read and write FSMs run fully in parallel. Same-word read and write in the same cycle returns the old data.
- len=0 is a single beat. len=255 (256 beats) is supported; beat counters are 8 bits.

Test Plan:
1. Single write then read: AW addr=0x10 len=0, W data=0xDEADBEEF wstrb=0xF wlast=1 -> bresp=0, bid=awid. AR addr=0x10 len=0 -> rdata=0xDEADBEEF, rlast=1, first rvalid 2 cycles after AR handshake.
2. Cache line burst: write len=3 at 0x100, data 1..4 -> single B OKAY. Read len=3 at 0x100 -> 4 beats 1,2,3,4, rlast only on beat 4.
3. Partial strobes: word 0x11223344 then write 0xAABBCCDD wstrb=0x5 -> read 0x11BB33DD.
4. Backpressure and wrap: rready toggled randomly during len=7 read -> rdata/rlast stable while stalled. Write len=1 at last word -> second beat lands at word 0.
5. Protocol error and concurrency: wlast asserted on beat 2 of len=3 -> bresp=2'b10, all 4 beats written. Read burst overlapping a write burst -> both complete with correct data and no deadlock.
6. Reset mid-burst: assert rst during beat 2 of a len=7 read -> all outputs 0 next cycle, arready=1 the cycle after rst deasserts. Data written before reset reads back intact.

Source files
------------

// File: rtl/iob_cache_axi_mem.sv
// AXI4 slave memory behind the cache back-end master.
// Independent read/write FSMs over a byte-enabled word RAM.
module iob_cache_axi_mem #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int ID_W       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   axi_awid,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [7:0]        axi_awlen,
  input  logic [2:0]        axi_awsize,
  input  logic [1:0]        axi_awburst,
  input  logic              axi_awlock,
  input  logic [3:0]        axi_awcache,
  input  logic [2:0]        axi_awprot,
  input  logic [3:0]        axi_awqos,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic              axi_wlast,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [ID_W-1:0]   axi_bid,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic [ID_W-1:0]   axi_arid,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [7:0]        axi_arlen,
  input  logic [2:0]        axi_arsize,
  input  logic [1:0]        axi_arburst,
  input  logic              axi_arlock,
  input  logic [3:0]        axi_arcache,
  input  logic [2:0]        axi_arprot,
  input  logic [3:0]        axi_arqos,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic [ID_W-1:0]   axi_rid,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic              axi_rvalid,
  input  logic              axi_rready
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = MEM_ADDR_W - OFF_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_st_e;

  logic [DATA_W-1:0] mem [2**IDX_W];

  w_st_e w_st_q, w_st_d;
  logic awready_q, awready_d, wready_q, wready_d;
  logic bvalid_q, bvalid_d, werr_q, werr_d;
  logic [1:0] bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0] wbeat_q, wbeat_d, wlen_q, wlen_d;
  logic mem_we;

  r_st_e r_st_q, r_st_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic rlast_q, rlast_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0] rbeat_q, rbeat_d, rlen_q, rlen_d;

  always_comb begin
    w_st_d    = w_st_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    widx_d    = widx_q;
    wbeat_d   = wbeat_q;
    wlen_d    = wlen_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    unique case (w_st_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi_awvalid && awready_q) begin
          w_st_d    = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = axi_awid;
          widx_d    = axi_awaddr[MEM_ADDR_W-1:OFF_W];
          wlen_d    = axi_awlen;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (axi_wvalid && wready_q) begin
          mem_we  = !rst;
          widx_d  = widx_q + IDX_W'(1);
          wbeat_d = wbeat_q + 8'd1;
          if (wbeat_q == wlen_q) begin
            w_st_d   = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q || !axi_wlast) ? 2'b10 : 2'b00;
          end else begin
            werr_d = werr_q | axi_wlast;
          end
        end
      end
      W_RESP: begin
        if (axi_bready && bvalid_q) begin
          w_st_d    = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
        end
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_st_d    = r_st_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    ridx_d    = ridx_q;
    rbeat_d   = rbeat_q;
    rlen_d    = rlen_q;
    unique case (r_st_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi_arvalid && arready_q) begin
          r_st_d    = R_FETCH;
          arready_d = 1'b0;
          rid_d     = axi_arid;
          ridx_d    = axi_araddr[MEM_ADDR_W-1:OFF_W];
          rlen_d    = axi_arlen;
          rbeat_d   = 8'd0;
        end
      end
      R_FETCH: begin
        r_st_d   = R_DATA;
        rvalid_d = 1'b1;
        rlast_d  = (rbeat_q == rlen_q);
        rdata_d  = mem[ridx_q];
      end
      R_DATA: begin
        if (axi_rready && rvalid_q) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            r_st_d    = R_IDLE;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            r_st_d  = R_FETCH;
            ridx_d  = ridx_q + IDX_W'(1);
            rbeat_d = rbeat_q + 8'd1;
          end
        end
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  // RAM has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (axi_wstrb[i]) mem[widx_q][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_st_q    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      widx_q    <= '0;
      wbeat_q   <= 8'd0;
      wlen_q    <= 8'd0;
      werr_q    <= 1'b0;
      r_st_q    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rbeat_q   <= 8'd0;
      rlen_q    <= 8'd0;
    end else begin
      w_st_q    <= w_st_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      widx_q    <= widx_d;
      wbeat_q   <= wbeat_d;
      wlen_q    <= wlen_d;
      werr_q    <= werr_d;
      r_st_q    <= r_st_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      ridx_q    <= ridx_d;
      rbeat_q   <= rbeat_d;
      rlen_q    <= rlen_d;
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_bid     = bid_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rid     = rid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{axi_awaddr, axi_awsize, axi_awburst, axi_awlock,
                       axi_awcache, axi_awprot, axi_awqos, axi_araddr,
                       axi_arsize, axi_arburst, axi_arlock, axi_arcache,
                       axi_arprot, axi_arqos};
endmodule

// File: tb/tb_iob_cache_axi_mem.sv
// Directed bench for iob_cache_axi_mem.
// Expected data comes from hand-written vectors and burst patterns.
module tb_iob_cache_axi_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic awvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [0:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_cache_axi_mem dut (
    .clk(clk), .rst(rst),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awsize(3'd2), .axi_awburst(2'b01), .axi_awlock(1'b0),
    .axi_awcache(4'd0), .axi_awprot(3'd0), .axi_awqos(4'd0),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
    .axi_bready(bready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
    .axi_arsize(3'd2), .axi_arburst(2'b01), .axi_arlock(1'b0),
    .axi_arcache(4'd0), .axi_arprot(3'd0), .axi_arqos(4'd0),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp),
    .axi_rlast(rlast), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic id, input logic [31:0] a, input int len);
    awid = id; awaddr = a; awlen = 8'(len); awvalid = 1'b1;
    for (int n = 0; n < 20 && !awready; n++) tick();
    chk("awready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int n = 0; n < 20 && !wready; n++) tick();
    chk("wready", 64'(wready), 64'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic b_get(input logic id, input logic [1:0] resp);
    bready = 1'b1;
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    chk("bvalid", 64'(bvalid), 64'd1);
    chk("bresp", 64'(bresp), 64'(resp));
    chk("bid", 64'(bid), 64'(id));
    tick();
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] a, input int len);
    arid = id; araddr = a; arlen = 8'(len); arvalid = 1'b1;
    for (int n = 0; n < 20 && !arready; n++) tick();
    chk("arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_get(input logic id, input logic [31:0] d, input logic l);
    rready = 1'b1;
    for (int n = 0; n < 20 && !rvalid; n++) tick();
    chk("rvalid", 64'(rvalid), 64'd1);
    chk("rdata", 64'(rdata), 64'(d));
    chk("rlast", 64'(rlast), 64'(l));
    chk("rid", 64'(rid), 64'(id));
    chk("rresp", 64'(rresp), 64'd0);
    tick();
    rready = 1'b0;
  endtask

  task automatic wr_inc(input logic id, input logic [31:0] a, input int len,
                        input logic [31:0] start, input int bad,
                        input logic [1:0] resp);
    aw_send(id, a, len);
    for (int i = 0; i <= len; i++)
      w_beat(start + 32'(i), 4'hF, (bad < 0) ? (i == len) : (i == bad));
    b_get(id, resp);
  endtask

  task automatic rd_inc(input logic id, input logic [31:0] a, input int len,
                        input logic [31:0] start);
    ar_send(id, a, len);
    for (int i = 0; i <= len; i++) r_get(id, start + 32'(i), i == len);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, 64'({awready, wready, bvalid, arready, rvalid, rlast,
                           bid, rid, bresp, rresp}), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_d;
    logic hold_l;
    int beat;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk("arready_post_rst", 64'(arready), 64'd1);
    chk("awready_post_rst", 64'(awready), 64'd1);

    // single write and read, first rvalid two cycles after AR handshake
    aw_send(1'b1, 32'h10, 0);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    b_get(1'b1, 2'b00);
    ar_send(1'b1, 32'h10, 0);
    chk("rvalid_lat1", 64'(rvalid), 64'd0);
    tick();
    chk("rvalid_lat2", 64'(rvalid), 64'd1);
    r_get(1'b1, 32'hDEADBEEF, 1'b1);

    // cache line burst
    wr_inc(1'b0, 32'h100, 3, 32'd1, -1, 2'b00);
    rd_inc(1'b0, 32'h100, 3, 32'd1);

    // partial strobes
    aw_send(1'b0, 32'h500, 0);
    w_beat(32'h11223344, 4'hF, 1'b1);
    b_get(1'b0, 2'b00);
    aw_send(1'b0, 32'h500, 0);
    w_beat(32'hAABBCCDD, 4'h5, 1'b1);
    b_get(1'b0, 2'b00);
    ar_send(1'b0, 32'h500, 0);
    r_get(1'b0, 32'h11BB33DD, 1'b1);

    // backpressure with random rready
    wr_inc(1'b1, 32'h200, 7, 32'hA0, -1, 2'b00);
    ar_send(1'b1, 32'h200, 7);
    beat = 0;
    for (int n = 0; n < 200 && beat < 8; n++) begin
      rready = 1'($urandom_range(0, 1));
      if (rvalid && rready) begin
        chk("bp_rdata", 64'(rdata), 64'(32'hA0 + 32'(beat)));
        chk("bp_rlast", 64'(rlast), 64'(beat == 7));
        tick();
        beat++;
      end else if (rvalid) begin
        hold_d = rdata;
        hold_l = rlast;
        tick();
        chk("bp_hold_v", 64'(rvalid), 64'd1);
        chk("bp_hold_d", 64'(rdata), 64'(hold_d));
        chk("bp_hold_l", 64'(rlast), 64'(hold_l));
      end else begin
        tick();
      end
    end
    rready = 1'b0;
    chk("bp_beats", 64'(beat), 64'd8);

    // wrap from last word to word 0
    wr_inc(1'b0, 32'hFFFC, 1, 32'h55, -1, 2'b00);
    ar_send(1'b0, 32'h0, 0);
    r_get(1'b0, 32'h56, 1'b1);
    ar_send(1'b0, 32'hFFFC, 0);
    r_get(1'b0, 32'h55, 1'b1);

    // early wlast flags SLVERR but all beats land
    wr_inc(1'b1, 32'h300, 3, 32'h30, 1, 2'b10);
    rd_inc(1'b1, 32'h300, 3, 32'h30);
    wr_inc(1'b0, 32'h310, 1, 32'h70, 5, 2'b10);
    rd_inc(1'b0, 32'h310, 1, 32'h70);

    // overlapping read and write bursts
    fork
      wr_inc(1'b1, 32'h400, 3, 32'h40, -1, 2'b00);
      rd_inc(1'b0, 32'h100, 3, 32'd1);
    join
    rd_inc(1'b1, 32'h400, 3, 32'h40);

    // reset during second beat of a read burst
    ar_send(1'b1, 32'h200, 7);
    r_get(1'b1, 32'hA0, 1'b0);
    for (int n = 0; n < 20 && !rvalid; n++) tick();
    chk("rst_beat2_v", 64'(rvalid), 64'd1);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    tick();
    chk("arready_after", 64'(arready), 64'd1);
    chk("rvalid_after", 64'(rvalid), 64'd0);
    rd_inc(1'b0, 32'h200, 7, 32'hA0);
    rd_inc(1'b0, 32'h10, 0, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
